key_source_arbiter: RTL
=======================

KEY_SOURCE_ARBITER -- requirements
Module: key_source_arbiter

Interface
REQ-001 SHALL have parameter IDLE_TIMEOUT, default 2000, owner-key-low cycles before ownership is released (minimum 2).
REQ-002 SHALL have parameter DELAY_STAGES, default 5, key_out pipeline depth in cycles (minimum 1).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port ext_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port b_local  input  1  local key, already synchronous to clk.
REQ-006 SHALL have port b_ext  input  1  external key, already synchronous to clk.
REQ-007 SHALL have port key_out  output  1  granted key, delayed, to decoder.
REQ-008 SHALL have port dec_rst  output  1  decoder reset: ext_rst OR one-cycle handover pulse.
REQ-009 SHALL have port owner  output  2  current owner: 00 none, 01 local, 10 ext.
REQ-010 SHALL have port led  output  1  high while last_owner is local.

Function
REQ-011 SHALL implement FSM states IDLE, OWN_LOC, OWN_EXT, FLUSH; owner = 01 in OWN_LOC, 10 in OWN_EXT, else 00.
REQ-012 IDLE: b_local only -> OWN_LOC; b_ext only -> OWN_EXT; neither -> stay IDLE.
REQ-013 IDLE with both keys high in the same cycle SHALL resolve per REQ-027.
REQ-014 On the IDLE grant edge, the granted key's high sample SHALL enter the delay line; no press is lost.
REQ-015 In OWN_LOC/OWN_EXT, the delay-line input SHALL be the owner's key; the non-owner key SHALL be ignored entirely.
REQ-016 In IDLE and FLUSH, the delay-line input SHALL be 0.
REQ-017 key_out SHALL equal the delay-line input sampled DELAY_STAGES rising edges earlier.
REQ-018 Idle counter, width $clog2(IDLE_TIMEOUT): cleared while owner key high or outside OWN states; increments each owned cycle with owner key low.
REQ-019 When the idle counter equals IDLE_TIMEOUT-1 with owner key still low, SHALL go to FLUSH next edge; the counter SHALL never wrap.
REQ-020 FLUSH SHALL last exactly DELAY_STAGES cycles, then IDLE; keys pressed during FLUSH SHALL be ignored.
REQ-021 last_owner register SHALL update on every grant; dec_rst SHALL pulse for exactly the one cycle after a grant whose owner differs from the previous last_owner.
REQ-022 Re-grant to the same source SHALL NOT pulse dec_rst.

Reset
REQ-023 ext_rst SHALL asynchronously force state IDLE, idle counter 0, delay line all 0, last_owner none.
REQ-024 During and after reset: key_out 0, owner 00, led 0; dec_rst SHALL be 1 while ext_rst is high.
REQ-025 First grant after reset SHALL pulse dec_rst (last_owner none differs from any source).
REQ-026 ext_rst mid-ownership SHALL discard in-flight key samples; no partial pulse SHALL appear on key_out after release.

Configuration
REQ-027 With KEY_ARB_EXT_PRIORITY_EN defined, a simultaneous IDLE request SHALL grant ext; without it, local SHALL win.

Structure
REQ-028 Package morse_pkg SHALL hold the FSM state enum and the owner codes (NONE, LOCAL, EXT).
REQ-029 The delay pipeline SHALL be sub-module key_delay_line (parameter DELAY_STAGES, async reset, shift register).

Verification (IDLE_TIMEOUT=8, DELAY_STAGES=5)
REQ-030 Reset, then b_local high 3 cycles -> owner 01, dec_rst pulse 1 cycle after grant, key_out high 3 cycles starting 5 cycles after first press, led 1.
REQ-031 Local owns, b_ext toggled -> key_out carries only b_local pattern; owner stays 01.
REQ-032 Owner key low 8 cycles -> FLUSH 5 cycles, owner 00, then IDLE; next b_ext press -> owner 10, dec_rst pulse, led 0.
REQ-033 Both keys rise same cycle in IDLE -> owner 01 without macro, 10 with KEY_ARB_EXT_PRIORITY_EN.
REQ-034 Timeout then b_local again -> owner 01, no dec_rst pulse.
REQ-035 ext_rst asserted mid-press -> key_out 0 immediately and for 5 following cycles, owner 00, dec_rst high during reset.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types for the key source arbiter: FSM state encoding and owner codes.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_LOC = 2'd1,
        OWN_EXT = 2'd2,
        FLUSH   = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        LOCAL = 2'b01,
        EXT   = 2'b10
    } owner_e;

    // Only the two ownership states map to a source; IDLE and FLUSH report none.
    function automatic owner_e owner_of(input arb_state_e s);
        case (s)
            OWN_LOC: return LOCAL;
            OWN_EXT: return EXT;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/key_delay_line.sv
// Fixed-depth shift register delaying the granted key by DELAY_STAGES clock edges.
module key_delay_line #(
    parameter int DELAY_STAGES = 5
) (
    input  logic clk,
    input  logic ext_rst,
    input  logic din,
    output logic dout
);

    logic [DELAY_STAGES-1:0] taps;

    // Async clear drops every in-flight sample so no partial pulse leaks out.
    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DELAY_STAGES; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DELAY_STAGES-1];

endmodule

// File: rtl/key_source_arbiter.sv
// Grants the decoder key path to the local or external key source, with idle release and flush.
// Define KEY_ARB_EXT_PRIORITY_EN to let the external key win a simultaneous request in IDLE.
module key_source_arbiter
    import morse_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 2000,
    parameter int DELAY_STAGES = 5
) (
    input  logic       clk,
    input  logic       ext_rst,
    input  logic       b_local,
    input  logic       b_ext,
    output logic       key_out,
    output logic       dec_rst,
    output logic [1:0] owner,
    output logic       led,
    output arb_state_e state_dbg
);

    localparam int IW = $clog2(IDLE_TIMEOUT);
    localparam int FW = (DELAY_STAGES > 1) ? $clog2(DELAY_STAGES) : 1;
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(DELAY_STAGES - 1);

`ifdef KEY_ARB_EXT_PRIORITY_EN
    localparam owner_e TIE_WINNER = EXT;
`else
    localparam owner_e TIE_WINNER = LOCAL;
`endif

    arb_state_e    state, state_nxt;
    logic [IW-1:0] idle_cnt;
    logic [FW-1:0] flush_cnt;
    owner_e        last_owner;
    owner_e        grant_src;
    logic          grant;
    logic          owned;
    logic          own_key;
    logic          din;
    logic          handover_q;

    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_src = NONE;
        own_key   = 1'b0;
        din       = 1'b0;
        case (state)
            IDLE: begin
                if (b_local && b_ext) begin
                    grant     = 1'b1;
                    grant_src = TIE_WINNER;
                end else if (b_local) begin
                    grant     = 1'b1;
                    grant_src = LOCAL;
                end else if (b_ext) begin
                    grant     = 1'b1;
                    grant_src = EXT;
                end
                // The granting press itself is the first sample into the delay line.
                if (grant) begin
                    din = 1'b1;
                    if (grant_src == LOCAL) begin
                        state_nxt = OWN_LOC;
                    end else begin
                        state_nxt = OWN_EXT;
                    end
                end
            end
            OWN_LOC: begin
                own_key = b_local;
                din     = b_local;
                if (!b_local && idle_cnt == IDLE_LAST) begin
                    state_nxt = FLUSH;
                end
            end
            OWN_EXT: begin
                own_key = b_ext;
                din     = b_ext;
                if (!b_ext && idle_cnt == IDLE_LAST) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign owned = (state == OWN_LOC) || (state == OWN_EXT);

    // Counters clear on their terminal value, so neither can wrap.
    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            idle_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (owned && !own_key && idle_cnt != IDLE_LAST) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
            if (state == FLUSH && flush_cnt != FLUSH_LAST) begin
                flush_cnt <= flush_cnt + 1'b1;
            end else begin
                flush_cnt <= '0;
            end
        end
    end

    // Decoder reset pulses only when the key source actually changes.
    always_ff @(posedge clk or posedge ext_rst) begin
        if (ext_rst) begin
            last_owner <= NONE;
            handover_q <= 1'b0;
        end else begin
            handover_q <= grant && (grant_src != last_owner);
            if (grant) begin
                last_owner <= grant_src;
            end
        end
    end

    key_delay_line #(
        .DELAY_STAGES(DELAY_STAGES)
    ) u_delay (
        .clk    (clk),
        .ext_rst(ext_rst),
        .din    (din),
        .dout   (key_out)
    );

    assign owner     = owner_of(state);
    assign led       = (last_owner == LOCAL);
    assign dec_rst   = ext_rst | handover_q;
    assign state_dbg = state;

endmodule
